// File: rtl/id_bitmap_alloc_if.sv
// Handshake bundle for the bitmap ID allocator.
// The _o / _i suffixes are from the allocator's point of view.
// The allocator connects through the slave modport; the consumer and
// completion path connect through the master modport.
interface id_bitmap_alloc_if #(
  parameter int NUM_ID = 8
);
  localparam int ID_W = $clog2(NUM_ID);

  logic              alloc_valid_o;
  logic              alloc_ready_i;
  logic [ID_W-1:0]   alloc_id_o;
  logic [NUM_ID-1:0] alloc_onehot_o;
  logic              free_valid_i;
  logic [ID_W-1:0]   free_id_i;
  logic [NUM_ID-1:0] busy_o;
  logic [ID_W:0]     outstanding_o;
  logic              full_o;
  logic              err_free_o;

  modport slave (
    output alloc_valid_o, alloc_id_o, alloc_onehot_o,
    output busy_o, outstanding_o, full_o, err_free_o,
    input  alloc_ready_i, free_valid_i, free_id_i
  );

  modport master (
    input  alloc_valid_o, alloc_id_o, alloc_onehot_o,
    input  busy_o, outstanding_o, full_o, err_free_o,
    output alloc_ready_i, free_valid_i, free_id_i
  );
endinterface

// File: rtl/id_bitmap_alloc.sv
// Bitmap ID allocator.
// A busy bitmap tracks every ID that is either handed out or currently
// offered. A priority pick over the registered bitmap chooses the next
// free ID, which is parked in an output register and offered through a
// valid/ready handshake. IDs come back on the free port; frees that do
// not match a handed-out ID are dropped and flagged for one cycle.
module id_bitmap_alloc #(
  parameter int NUM_ID    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  id_bitmap_alloc_if.slave bus
);
  localparam int ID_W  = $clog2(NUM_ID);
  localparam int CNT_W = ID_W + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [NUM_ID-1:0] onehot_q, onehot_d;
  logic [NUM_ID-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              err_q, err_d;

  logic [NUM_ID-1:0] free_dec;
  logic [NUM_ID-1:0] free_clear;
  logic              free_legal;
  logic [NUM_ID-1:0] avail;
  logic [NUM_ID-1:0] avail_ord;
  logic [NUM_ID-1:0] iso_ord;
  logic [NUM_ID-1:0] pick_onehot;
  logic [ID_W-1:0]   pick_id;
  logic              has_free;
  logic              transfer;
  logic              can_load;

  genvar gi;

  // Decode the returned ID. Out-of-range IDs match no bit, so they can
  // never clear anything and fall through as illegal.
  generate
    for (gi = 0; gi < NUM_ID; gi++) begin : g_free_dec
      assign free_dec[gi] = bus.free_valid_i && (bus.free_id_i == ID_W'(gi));
    end
  endgenerate

  // A free is legal only for an ID that is busy but not the one on offer;
  // the offered ID has not been accepted yet, so nobody may return it.
  assign free_clear = free_dec & busy_q & ~onehot_q;
  assign free_legal = |free_clear;

  // Candidate IDs come from the registered bitmap only, so an ID freed
  // this cycle is not eligible until the following edge.
  assign avail    = ~busy_q;
  assign has_free = |avail;

  // Bring the preferred end of the bitmap to bit 0 so a single
  // lowest-set-bit isolate serves both priority directions.
  generate
    for (gi = 0; gi < NUM_ID; gi++) begin : g_order
      if (LSB_FIRST) begin : g_lsb
        assign avail_ord[gi]   = avail[gi];
        assign pick_onehot[gi] = iso_ord[gi];
      end else begin : g_msb
        assign avail_ord[gi]   = avail[NUM_ID-1-gi];
        assign pick_onehot[gi] = iso_ord[NUM_ID-1-gi];
      end
    end
  endgenerate

  assign iso_ord = avail_ord & (~avail_ord + NUM_ID'(1));

  // One-hot to binary encode of the picked slot.
  always_comb begin
    pick_id = '0;
    for (int i = 0; i < NUM_ID; i++) begin
      if (pick_onehot[i]) begin
        pick_id = pick_id | ID_W'(i);
      end
    end
  end

  assign transfer = (state_q == ST_HOLD) && bus.alloc_ready_i;
  assign can_load = (state_q == ST_EMPTY) || bus.alloc_ready_i;

  // Next-state: refill the output register whenever it is empty or being
  // drained, apply legal frees to the bitmap and track accepted IDs.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    onehot_d      = onehot_q;
    busy_d        = busy_q & ~free_clear;
    outstanding_d = outstanding_q;
    err_d         = bus.free_valid_i && !free_legal;

    if (can_load) begin
      if (has_free) begin
        state_d  = ST_HOLD;
        id_d     = pick_id;
        onehot_d = pick_onehot;
        busy_d   = busy_d | pick_onehot;
      end else begin
        // Binary ID keeps its last value; only the one-hot must read 0.
        state_d  = ST_EMPTY;
        onehot_d = '0;
      end
    end

    case ({transfer, free_legal})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_EMPTY;
      id_q          <= '0;
      onehot_q      <= '0;
      busy_q        <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      onehot_q      <= onehot_d;
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign bus.alloc_valid_o  = (state_q == ST_HOLD);
  assign bus.alloc_id_o     = id_q;
  assign bus.alloc_onehot_o = onehot_q;
  assign bus.busy_o         = busy_q;
  assign bus.outstanding_o  = outstanding_q;
  assign bus.full_o         = &busy_q;
  assign bus.err_free_o     = err_q;

endmodule

// File: tb/tb_id_bitmap_alloc.sv
// Bench for id_bitmap_alloc: table vectors and directed sequences on a
// 4-ID LSB-first and an 8-ID MSB-first instance, then random traffic on a
// 6-ID MSB-first instance checked against a set-based reference model.
module tb_id_bitmap_alloc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_bitmap_alloc_if #(.NUM_ID(4)) ifa ();
  id_bitmap_alloc_if #(.NUM_ID(8)) ifb ();
  id_bitmap_alloc_if #(.NUM_ID(6)) ifc ();

  id_bitmap_alloc #(.NUM_ID(4), .LSB_FIRST(1'b1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  id_bitmap_alloc #(.NUM_ID(8), .LSB_FIRST(1'b0)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
  id_bitmap_alloc #(.NUM_ID(6), .LSB_FIRST(1'b0)) dut_c (.clk_i(clk), .rst_i(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int v; int id; int oh; int busy; int out; int full; int err;
  } obs_t;

  typedef struct {
    bit ready; bit fv; int fid;
    bit v; int id; int busy; int out; bit full; bit err;
  } vec_t;

  function automatic obs_t mk(input int v, input int id, input int busy,
                              input int out, input int full, input int err);
    obs_t o;
    o.v = v; o.id = id; o.oh = v ? (1 << id) : 0;
    o.busy = busy; o.out = out; o.full = full; o.err = err;
    return o;
  endfunction

  function automatic obs_t get_a();
    return '{int'(ifa.alloc_valid_o), int'(ifa.alloc_id_o), int'(ifa.alloc_onehot_o),
             int'(ifa.busy_o), int'(ifa.outstanding_o), int'(ifa.full_o), int'(ifa.err_free_o)};
  endfunction

  function automatic obs_t get_b();
    return '{int'(ifb.alloc_valid_o), int'(ifb.alloc_id_o), int'(ifb.alloc_onehot_o),
             int'(ifb.busy_o), int'(ifb.outstanding_o), int'(ifb.full_o), int'(ifb.err_free_o)};
  endfunction

  function automatic obs_t get_c();
    return '{int'(ifc.alloc_valid_o), int'(ifc.alloc_id_o), int'(ifc.alloc_onehot_o),
             int'(ifc.busy_o), int'(ifc.outstanding_o), int'(ifc.full_o), int'(ifc.err_free_o)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
    chk({tag, ".valid"}, act.v, exp.v);
    if (exp.v != 0) chk({tag, ".id"}, act.id, exp.id);
    chk({tag, ".onehot"}, act.oh, exp.oh);
    chk({tag, ".busy"}, act.busy, exp.busy);
    chk({tag, ".outstanding"}, act.out, exp.out);
    chk({tag, ".full"}, act.full, exp.full);
    chk({tag, ".err"}, act.err, exp.err);
  endtask

  task automatic idle_all();
    ifa.alloc_ready_i = 1'b0; ifa.free_valid_i = 1'b0; ifa.free_id_i = '0;
    ifb.alloc_ready_i = 1'b0; ifb.free_valid_i = 1'b0; ifb.free_id_i = '0;
    ifc.alloc_ready_i = 1'b0; ifc.free_valid_i = 1'b0; ifc.free_id_i = '0;
  endtask

  // Hold reset across an edge, check the reset state, release at negedge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    idle_all();
    @(posedge clk);
    #1;
    chk_obs({tag, ".rst_a"}, get_a(), mk(0, 0, 0, 0, 0, 0));
    chk({tag, ".rst_a.id"}, int'(ifa.alloc_id_o), 0);
    chk_obs({tag, ".rst_b"}, get_b(), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step_a(input bit r, input bit fv, input int fid);
    ifa.alloc_ready_i = r; ifa.free_valid_i = fv; ifa.free_id_i = 2'(fid);
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input bit r, input bit fv, input int fid);
    ifb.alloc_ready_i = r; ifb.free_valid_i = fv; ifb.free_id_i = 3'(fid);
    @(posedge clk);
    #1;
  endtask

  // Reference model state for the random phase: which IDs are held by the
  // consumer, and what (if anything) is on offer.
  localparam int RN = 6;
  bit handed[RN];
  bit m_valid;
  int m_id;

  initial begin
    vec_t tbl[9];
    obs_t exp_o;

    idle_all();

    // ---------------- table vectors, 4-ID LSB-first ----------------
    //          rdy fv fid   v id busy    out full err
    tbl[0] = '{1, 0, 0,    1, 0, 4'b0001, 0, 0, 0};
    tbl[1] = '{1, 0, 0,    1, 1, 4'b0011, 1, 0, 0};
    tbl[2] = '{1, 0, 0,    1, 2, 4'b0111, 2, 0, 0};
    tbl[3] = '{1, 0, 0,    1, 3, 4'b1111, 3, 1, 0};
    tbl[4] = '{1, 0, 0,    0, 0, 4'b1111, 4, 1, 0};
    tbl[5] = '{0, 1, 2,    0, 0, 4'b1011, 3, 0, 0};
    tbl[6] = '{0, 0, 0,    1, 2, 4'b1111, 3, 1, 0};
    tbl[7] = '{0, 1, 2,    1, 2, 4'b1111, 3, 1, 1};
    tbl[8] = '{0, 0, 0,    1, 2, 4'b1111, 3, 1, 0};

    do_reset("tbl");
    for (int i = 0; i < 9; i++) begin
      step_a(tbl[i].ready, tbl[i].fv, tbl[i].fid);
      $display("vec %0d ready=%0d free=%0d/%0d -> valid=%0d id=%0d busy=%b out=%0d err=%0d",
               i, tbl[i].ready, tbl[i].fv, tbl[i].fid, ifa.alloc_valid_o, ifa.alloc_id_o,
               ifa.busy_o, ifa.outstanding_o, ifa.err_free_o);
      chk_obs($sformatf("tbl%0d", i), get_a(),
              mk(tbl[i].v, tbl[i].id, tbl[i].busy, tbl[i].out, tbl[i].full, tbl[i].err));
    end

    // ---------------- offer stays put while consumer stalls ----------------
    do_reset("stall");
    for (int i = 0; i < 6; i++) begin
      step_a(1'b0, 1'b0, 0);
      chk_obs($sformatf("stall%0d", i), get_a(), mk(1, 0, 4'b0001, 0, 0, 0));
    end
    $display("stall: id 0 held for 6 cycles");

    // ---------------- illegal frees, then transfer+free same cycle ----------------
    do_reset("ill");
    step_a(1'b1, 1'b0, 0);
    chk_obs("ill.off0", get_a(), mk(1, 0, 4'b0001, 0, 0, 0));
    step_a(1'b1, 1'b0, 0);
    chk_obs("ill.off1", get_a(), mk(1, 1, 4'b0011, 1, 0, 0));
    step_a(1'b0, 1'b1, 3);
    chk_obs("ill.notbusy", get_a(), mk(1, 1, 4'b0011, 1, 0, 1));
    step_a(1'b0, 1'b1, 1);
    chk_obs("ill.offered", get_a(), mk(1, 1, 4'b0011, 1, 0, 1));
    step_a(1'b0, 1'b0, 0);
    chk_obs("ill.pulse_end", get_a(), mk(1, 1, 4'b0011, 1, 0, 0));
    step_a(1'b1, 1'b1, 1);
    chk_obs("ill.offered_rdy", get_a(), mk(1, 2, 4'b0111, 2, 0, 1));
    step_a(1'b1, 1'b1, 0);
    chk_obs("xfer_free", get_a(), mk(1, 3, 4'b1110, 2, 0, 0));
    $display("xfer+free: outstanding=%0d busy=%b", ifa.outstanding_o, ifa.busy_o);

    // Async reset between edges must clear outputs without a clock edge.
    step_a(1'b0, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_obs("async_rst", get_a(), mk(0, 0, 0, 0, 0, 0));
    chk("async_rst.id", int'(ifa.alloc_id_o), 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- 8-ID MSB-first ----------------
    do_reset("msb");
    step_b(1'b1, 1'b0, 0);
    chk_obs("msb.7", get_b(), mk(1, 7, 8'h80, 0, 0, 0));
    step_b(1'b1, 1'b0, 0);
    chk_obs("msb.6", get_b(), mk(1, 6, 8'hC0, 1, 0, 0));
    step_b(1'b1, 1'b0, 0);
    chk_obs("msb.5", get_b(), mk(1, 5, 8'hE0, 2, 0, 0));
    step_b(1'b0, 1'b1, 6);
    chk_obs("msb.free6", get_b(), mk(1, 5, 8'hA0, 1, 0, 0));
    step_b(1'b1, 1'b0, 0);
    chk_obs("msb.reoffer6", get_b(), mk(1, 6, 8'hE0, 2, 0, 0));
    step_b(1'b1, 1'b0, 0);
    chk_obs("msb.4", get_b(), mk(1, 4, 8'hF0, 3, 0, 0));
    $display("msb: offered sequence 7,6,5,6,4");

    // ---------------- random traffic vs reference model ----------------
    do_reset("rnd");
    for (int i = 0; i < RN; i++) handed[i] = 1'b0;
    m_valid = 1'b0;
    m_id = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit r, fv, legal, xfer, found;
      bit busy_old[RN];
      int fid, bexp, oexp, pick, xfer_id;
      int hl[$];

      r  = ((cyc / 200) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      fv = $urandom_range(0, 1) == 1;
      hl.delete();
      for (int i = 0; i < RN; i++) if (handed[i]) hl.push_back(i);
      if (hl.size() > 0 && $urandom_range(0, 3) != 0) fid = hl[$urandom_range(0, hl.size() - 1)];
      else fid = $urandom_range(0, 7);

      // Model: busy = held IDs plus the one on offer, as of before the edge.
      for (int i = 0; i < RN; i++) busy_old[i] = handed[i] || (m_valid && m_id == i);
      legal   = fv && fid < RN && handed[fid];
      xfer    = m_valid && r;
      xfer_id = m_id;
      if (xfer) handed[m_id] = 1'b1;
      if (legal) handed[fid] = 1'b0;
      if (!m_valid || r) begin
        found = 1'b0;
        pick = 0;
        for (int i = RN - 1; i >= 0; i--) begin
          if (!found && !busy_old[i]) begin
            found = 1'b1;
            pick = i;
          end
        end
        m_valid = found;
        if (found) m_id = pick;
      end
      bexp = 0;
      oexp = 0;
      for (int i = 0; i < RN; i++) begin
        if (handed[i]) oexp++;
        if (handed[i] || (m_valid && m_id == i)) bexp |= (1 << i);
      end
      exp_o = mk(m_valid, m_id, bexp, oexp, (bexp == 6'h3F) ? 1 : 0, (fv && !legal) ? 1 : 0);

      ifc.alloc_ready_i = r;
      ifc.free_valid_i  = fv;
      ifc.free_id_i     = 3'(fid);
      @(posedge clk);
      #1;
      chk_obs($sformatf("rnd%0d", cyc), get_c(), exp_o);
      chk($sformatf("rnd%0d.invariant", cyc),
          int'(ifc.outstanding_o) + int'(ifc.alloc_valid_o), $countones(ifc.busy_o));
      if (xfer)
        $display("rnd %0d: alloc id %0d free=%0d/%0d legal=%0d busy=%b out=%0d",
                 cyc, xfer_id, fv, fid, legal, ifc.busy_o, ifc.outstanding_o);
    end
    idle_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
